// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit mux_4_1 between four valid/ready requesters,
// with a one-entry registered output stage.

module mux_4_1 (
  input  logic [1:0] sel,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module mux_4_1_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_valid,
  input  logic [3:0] in_data_0,
  input  logic [3:0] in_data_1,
  input  logic [3:0] in_data_2,
  input  logic [3:0] in_data_3,
  output logic [3:0] in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic [1:0] out_src,
  input  logic       out_ready
);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [1:0] last;
  logic [1:0] grant;
  logic [1:0] idx;
  logic       found;
  logic       any;
  logic       can_load;
  logic       load;
  logic [3:0] mux_y;

  assign any      = |in_valid;
  assign can_load = (out_valid == EMPTY) | out_ready;
  assign load     = can_load & any;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    grant = last;
    found = 1'b0;
    idx   = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Gated by rst_n so no requester sees a handshake while reset is held.
  assign in_ready = (load && rst_n) ? (4'b0001 << grant) : 4'b0000;

  mux_4_1 u_mux (
    .sel (grant),
    .d0  (in_data_0),
    .d1  (in_data_1),
    .d2  (in_data_2),
    .d3  (in_data_3),
    .y   (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= EMPTY;
      out_data  <= 4'h0;
      out_src   <= 2'd0;
      last      <= 2'd3;
    end else if (load) begin
      out_valid <= FULL;
      out_data  <= mux_y;
      out_src   <= grant;
      last      <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= EMPTY;
    end
  end
endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Scoreboard bench for mux_4_1_rr_arbiter: a driver predicts each accepted word from a
// rotating-priority model, and a monitor checks the output register against the queue.

module tb_mux_4_1_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_data_0, in_data_1, in_data_2, in_data_3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic       out_ready;

  typedef struct {
    logic [3:0] data;
    logic [1:0] src;
  } word_t;

  word_t      sb[$];
  int         total = 0;
  int         bad = 0;
  int         model_last = 3;
  bit         model_full = 0;
  logic [3:0] exp_in_ready = 4'h0;
  logic       exp_out_valid = 1'b0;
  bit         mon_en = 0;

  always #5 clk = ~clk;

  mux_4_1_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_0 (in_data_0),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .in_data_3 (in_data_3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next owner is the first active requester after the previous winner, wrapping mod 4.
  function automatic int refGrant(input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(model_last + k) % 4]) return (model_last + k) % 4;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [3:0] v, input logic r,
                               input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3);
    logic [3:0] d[4];
    int g;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    in_valid = v;
    out_ready = r;
    in_data_0 = d0;
    in_data_1 = d1;
    in_data_2 = d2;
    in_data_3 = d3;
    d = '{d0, d1, d2, d3};
    exp_out_valid = model_full;
    g = refGrant(v);
    if ((!model_full || r) && g >= 0) begin
      exp_in_ready = 4'b0001 << g;
      sb.push_back('{data: d[g], src: 2'(g)});
      model_last = g;
      model_full = 1;
    end else begin
      exp_in_ready = 4'h0;
      if (model_full && r) model_full = 0;
    end
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_full = 0;
    model_last = 3;
    exp_in_ready = 4'h0;
    exp_out_valid = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("midreset_out_data", {4'd0, out_data}, 8'd0);
    checkOutput("midreset_in_ready", {4'd0, in_ready}, 8'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checkOutput("in_ready", {4'd0, in_ready}, {4'd0, exp_in_ready});
        checkOutput("out_valid", {7'd0, out_valid}, {7'd0, exp_out_valid});
        if (out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got out_valid=1 with data %0h, wanted no word pending", out_data);
          end else begin
            checkOutput("out_data", {4'd0, out_data}, {4'd0, sb[0].data});
            checkOutput("out_src", {6'd0, out_src}, {6'd0, sb[0].src});
            if (out_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    in_data_0 = 4'hA;
    in_data_1 = 4'hB;
    in_data_2 = 4'hC;
    in_data_3 = 4'hD;
    #12;
    checkOutput("reset_out_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("reset_out_data", {4'd0, out_data}, 8'd0);
    checkOutput("reset_out_src", {6'd0, out_src}, 8'd0);
    checkOutput("reset_in_ready", {4'd0, in_ready}, 8'd0);
    mon_en = 1;

    $display("[TB] round robin");
    repeat (6) applyStimulus(4'hF, 1'b1, 4'hA, 4'hB, 4'hC, 4'hD);
    repeat (2) applyStimulus(4'h0, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);

    $display("[TB] backpressure");
    applyStimulus(4'b0001, 1'b1, 4'h5, 4'h7, 4'h8, 4'h9);
    repeat (3) applyStimulus(4'h6, 1'b0, 4'h1, 4'h2, 4'h3, 4'h4);
    applyStimulus(4'h6, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
    repeat (2) applyStimulus(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("[TB] skip idle requesters");
    applyStimulus(4'b0010, 1'b1, 4'h0, 4'hE, 4'h0, 4'h0);
    repeat (3) applyStimulus(4'b1001, 1'b1, 4'h3, 4'h0, 4'h0, 4'hC);
    repeat (3) applyStimulus(4'b0100, 1'b1, 4'h0, 4'h0, 4'h6, 4'h0);
    repeat (2) applyStimulus(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("[TB] mid-stream reset");
    repeat (3) applyStimulus(4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
    resetPulse();
    repeat (3) applyStimulus(4'hF, 1'b1, 4'h8, 4'h9, 4'hA, 4'hB);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                    4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if (i == 200) resetPulse();
    end
    repeat (3) applyStimulus(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk);
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
